// File: rtl/key_sched_ctrl.sv
// Round-key generator sequencer: round-robin arbitration between two key requesters,
// load + rounds 1..10 with settle gaps, and a single-entry cache of the expanded key.
module key_sched_ctrl #(
  parameter int BLOCK_LENGTH = 128,
  parameter int SETTLE       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [BLOCK_LENGTH-1:0] req_key0,
  input  logic [BLOCK_LENGTH-1:0] req_key1,
  output logic [1:0]              req_ready,
  input  logic                    flush,
  output logic                    gen_en,
  output logic [3:0]              gen_round,
  output logic [BLOCK_LENGTH-1:0] gen_key,
  output logic                    keys_valid,
  output logic                    keys_owner,
  output logic                    done,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STEP, DONE} state_t;

  localparam logic [1:0] SETTLE_LAST = (SETTLE > 0) ? 2'(SETTLE - 1) : 2'd0;
  localparam logic [3:0] LAST_ROUND  = 4'd10;

  state_t                  state_q, state_d;
  logic [3:0]              round_q, round_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [BLOCK_LENGTH-1:0] key_q, key_d;
  logic                    kv_q, kv_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;

  logic [1:0]              grant;
  logic                    accept;
  logic                    acc_idx;
  logic [BLOCK_LENGTH-1:0] acc_key;
  logic                    hit;

  // Grant only in IDLE; with both requesters pending, favour the one not served last.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && !flush) begin
      if (req_valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign accept  = |(req_valid & grant);
  assign acc_idx = grant[1];
  assign acc_key = acc_idx ? req_key1 : req_key0;
  assign hit     = kv_q && (acc_key == key_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      cnt_q        <= 2'd0;
      key_q        <= '0;
      kv_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      kv_q         <= kv_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    kv_d         = kv_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          key_d        = acc_key;
          owner_d      = acc_idx;
          last_grant_d = acc_idx;
          if (hit) begin
            state_d = DONE;
          end else begin
            kv_d    = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        round_d = 4'd1;
        cnt_d   = 2'd0;
        state_d = (SETTLE == 0) ? STEP : WAIT;
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) state_d = STEP;
        else                      cnt_d   = cnt_q + 2'd1;
      end
      STEP: begin
        cnt_d = 2'd0;
        // Bank becomes valid together with the done pulse, hence set on the way into DONE.
        if (round_q == LAST_ROUND) begin
          kv_d    = 1'b1;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = (SETTLE == 0) ? STEP : WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      kv_d    = 1'b0;
    end
  end

  // WAIT already presents the upcoming round so its constant reaches the g-stage early.
  always_comb begin
    gen_en    = (state_q == LOAD) || (state_q == STEP);
    gen_round = ((state_q == WAIT) || (state_q == STEP)) ? round_q : 4'd0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) && !flush;
  end

  assign req_ready  = grant;
  assign gen_key    = key_q;
  assign keys_valid = kv_q;
  assign keys_owner = owner_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: one instance with SETTLE=1, one with SETTLE=0.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   rv1 = 2'b00;
  logic [1:0]   rv0 = 2'b00;
  logic [127:0] req_key0 = '0;
  logic [127:0] req_key1 = '0;
  logic         flush = 1'b0;
  logic         use0 = 1'b0;

  logic [1:0]   g1_ready, g0_ready;
  logic         g1_en, g0_en;
  logic [3:0]   g1_round, g0_round;
  logic [127:0] g1_key, g0_key;
  logic         g1_kv, g0_kv, g1_owner, g0_owner, g1_done, g0_done, g1_busy, g0_busy;

  key_sched_ctrl #(.BLOCK_LENGTH(128), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_key0(req_key0), .req_key1(req_key1),
    .req_ready(g1_ready), .flush(flush), .gen_en(g1_en), .gen_round(g1_round),
    .gen_key(g1_key), .keys_valid(g1_kv), .keys_owner(g1_owner), .done(g1_done), .busy(g1_busy)
  );

  key_sched_ctrl #(.BLOCK_LENGTH(128), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_key0(req_key0), .req_key1(req_key1),
    .req_ready(g0_ready), .flush(flush), .gen_en(g0_en), .gen_round(g0_round),
    .gen_key(g0_key), .keys_valid(g0_kv), .keys_owner(g0_owner), .done(g0_done), .busy(g0_busy)
  );

  logic [1:0]   m_ready;
  logic         m_en, m_kv, m_owner, m_done, m_busy;
  logic [3:0]   m_round;
  logic [127:0] m_key;
  assign m_ready = use0 ? g0_ready : g1_ready;
  assign m_en    = use0 ? g0_en    : g1_en;
  assign m_round = use0 ? g0_round : g1_round;
  assign m_key   = use0 ? g0_key   : g1_key;
  assign m_kv    = use0 ? g0_kv    : g1_kv;
  assign m_owner = use0 ? g0_owner : g1_owner;
  assign m_done  = use0 ? g0_done  : g1_done;
  assign m_busy  = use0 ? g0_busy  : g1_busy;

  localparam logic [127:0] K  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] X0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] X1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int log_r[$];
  int log_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_en) begin
      log_r.push_back(int'(m_round));
      log_c.push_back(cyc);
    end
    if (m_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] v, input logic [127:0] k0, input logic [127:0] k1,
                           input int gidx, input bit hold);
    if (use0) rv0 = v; else rv1 = v;
    req_key0 = k0;
    req_key1 = k1;
    #1;
    chk("ready_grant", m_ready, (gidx == 1) ? 2'b10 : 2'b01);
    chk("idle_not_busy", m_busy, 0);
    log_r.delete();
    log_c.delete();
    t0 = cyc;
    @(posedge clk); #1;
    if (!hold) begin rv0 = 2'b00; rv1 = 2'b00; end
    chk("gen_key_latched", m_key, (gidx == 1) ? k1 : k0);
    chk("owner_latched", m_owner, gidx);
  endtask

  task automatic finish_req(input int gidx, input bit hit, input int s);
    int lat;
    int done_at;
    lat = hit ? 1 : 2 + 10 * (s + 1);
    done_at = -1;
    chk("kv_after_accept", m_kv, hit);
    for (int i = 1; i <= 60; i++) begin
      chk("busy_in_seq", m_busy, 1);
      chk("no_grant_busy", m_ready, 0);
      if (m_done) begin
        done_at = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_latency", done_at, lat);
    chk("kv_at_done", m_kv, 1);
    chk("owner_at_done", m_owner, gidx);
    chk("gen_en_count", log_r.size(), hit ? 0 : 11);
    for (int j = 0; j < log_r.size(); j++) begin
      chk("gen_round_seq", log_r[j], j);
      chk("gen_round_time", log_c[j], t0 + 1 + j * (s + 1));
    end
    @(posedge clk); #1;
    chk("idle_after_done", m_busy, 0);
  endtask

  initial begin
    int dc;
    bit found;
    // reset values
    #12;
    chk("rst_ready", m_ready, 0);
    chk("rst_gen_en", m_en, 0);
    chk("rst_gen_round", m_round, 0);
    chk("rst_gen_key", m_key, 0);
    chk("rst_kv", m_kv, 0);
    chk("rst_owner", m_owner, 0);
    chk("rst_done", m_done, 0);
    chk("rst_busy", m_busy, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // first request: miss, full 22-cycle sequence
    start_req(2'b01, K, 128'h0, 0, 0);
    finish_req(0, 0, 1);

    // same key from requester 1: hit
    start_req(2'b10, 128'h0, K, 1, 0);
    finish_req(1, 1, 1);

    // both held: grants alternate, each a miss
    start_req(2'b11, X0, X1, 0, 1);
    finish_req(0, 0, 1);
    start_req(2'b11, X0, X1, 1, 1);
    finish_req(1, 0, 1);
    start_req(2'b11, X0, X1, 0, 1);
    finish_req(0, 0, 1);
    start_req(2'b11, X0, X1, 1, 0);
    finish_req(1, 0, 1);

    // flush at round 5
    start_req(2'b01, K, 128'h0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_en && m_round == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reached_round5", found, 1);
    dc = done_cnt;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", m_busy, 0);
    chk("flush_gen_en", m_en, 0);
    chk("flush_kv", m_kv, 0);
    chk("flush_done", m_done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt, dc);
    start_req(2'b01, K, 128'h0, 0, 0);
    finish_req(0, 0, 1);

    // SETTLE=0 instance
    use0 = 1'b1;
    start_req(2'b01, K, 128'h0, 0, 0);
    finish_req(0, 0, 0);
    use0 = 1'b0;

    // asynchronous reset mid-sequence
    start_req(2'b10, 128'h0, X1, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_busy", m_busy, 1);
    rst = 1'b0;
    #1;
    chk("arst_ready", m_ready, 0);
    chk("arst_gen_en", m_en, 0);
    chk("arst_gen_round", m_round, 0);
    chk("arst_gen_key", m_key, 0);
    chk("arst_kv", m_kv, 0);
    chk("arst_owner", m_owner, 0);
    chk("arst_done", m_done, 0);
    chk("arst_busy", m_busy, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    start_req(2'b11, K, X0, 0, 0);
    finish_req(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
